// File: rtl/gamma_serializer_pkg.sv
// Shared types and defaults for the Elias-gamma serializer.
// State encoding, width defaults and the code-length helper.
package gamma_serializer_pkg;

  localparam int WIDTH_D = 64;
  localparam int LW_D    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFIX,
    S_BODY,
    S_DONE
  } state_t;

  // Gamma code length: len-1 zeros plus len value bits.
  function automatic logic [LW_D-1:0] gamma_code_len(
    input logic [LW_D-1:0] len
  );
    return (len << 1) - LW_D'(1);
  endfunction

endpackage

// File: rtl/gamma_bit_counter.sv
// Loadable down-counter with zero flag, reused for prefix and body.
// Ports: clk, rstn, load, load_val, dec, cnt, zero.
module gamma_bit_counter #(
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [LW-1:0] load_val,
  input  logic          dec,
  output logic [LW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - LW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gamma_serializer.sv
// Elias-gamma bit-serial encoder: len-1 zeros, then value MSB first.
// Ports: clk, rstn, md_start/num_in/len_in, out_ready, bit_* , busy, code_len, err, md_end.
module gamma_serializer
  import gamma_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int LW    = LW_D
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             md_start,
  input  logic [WIDTH-1:0] num_in,
  input  logic [LW-1:0]    len_in,
  input  logic             out_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             busy,
  output logic [LW-1:0]    code_len,
  output logic             err,
  output logic             md_end
);

  localparam int IW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] num_q;
  logic [LW-1:0]    len_q;
  logic             err_f, err_f_n;
  logic             latch;
  logic             ld, dec;
  logic [LW-1:0]    ld_val;
  logic [LW-1:0]    cnt;
  logic             cnt_zero;
  logic             bit_n, valid_n, last_n;
  logic [LW-1:0]    code_n;
  logic             xfer;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    nxt_idx;

  gamma_bit_counter #(.LW(LW)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign xfer    = bit_valid && out_ready;
  assign top_idx = len_q[IW-1:0] - IW'(1);
  assign nxt_idx = cnt[IW-1:0] - IW'(1);

  always_comb begin
    state_n = state;
    err_f_n = err_f;
    latch   = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    bit_n   = bit_out;
    valid_n = bit_valid;
    last_n  = bit_last;
    code_n  = code_len;
    unique case (state)
      S_IDLE: begin
        if (md_start) begin
          latch = 1'b1;
          if (len_in == '0 || len_in > LW'(WIDTH)) begin
            state_n = S_DONE;
            err_f_n = 1'b1;
            code_n  = '0;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            err_f_n = 1'b0;
            code_n  = LW'(gamma_code_len(LW_D'(len_in)));
            valid_n = 1'b1;
            ld      = 1'b1;
            if (len_in == LW'(1)) begin
              state_n = S_BODY;
              ld_val  = '0;
              bit_n   = num_in[0];
              last_n  = 1'b1;
            end else begin
              state_n = S_PREFIX;
              ld_val  = len_in - LW'(1);
              bit_n   = 1'b0;
              last_n  = 1'b0;
            end
          end
        end
      end
      S_PREFIX: begin
        if (xfer) begin
          if (cnt == LW'(1)) begin
            // Last zero gone: reload counter as body bit index.
            state_n = S_BODY;
            ld      = 1'b1;
            ld_val  = len_q - LW'(1);
            bit_n   = num_q[top_idx];
          end else begin
            dec   = 1'b1;
            bit_n = 1'b0;
          end
        end
      end
      S_BODY: begin
        if (xfer) begin
          if (cnt_zero) begin
            state_n = S_DONE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            bit_n   = 1'b0;
          end else begin
            dec    = 1'b1;
            bit_n  = num_q[nxt_idx];
            last_n = (cnt == LW'(1));
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      num_q     <= '0;
      len_q     <= '0;
      err_f     <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      busy      <= 1'b0;
      code_len  <= '0;
      err       <= 1'b0;
      md_end    <= 1'b0;
    end else begin
      state     <= state_n;
      err_f     <= err_f_n;
      bit_out   <= bit_n;
      bit_valid <= valid_n;
      bit_last  <= last_n;
      busy      <= (state_n != S_IDLE);
      code_len  <= code_n;
      md_end    <= (state == S_DONE);
      err       <= (state == S_DONE) && err_f;
      if (latch) begin
        num_q <= num_in;
        len_q <= len_in;
      end
    end
  end

endmodule

// File: tb/tb_gamma_serializer.sv
// Directed bench for gamma_serializer.
// Checks bit streams, handshake stalls, errors, reset abort.
module tb_gamma_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        md_start;
  logic [63:0] num_in;
  logic [7:0]  len_in;
  logic        out_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_last;
  logic        busy;
  logic [7:0]  code_len;
  logic        err;
  logic        md_end;

  int checks   = 0;
  int failures = 0;

  gamma_serializer dut (
    .clk       (clk),
    .rstn      (rstn),
    .md_start  (md_start),
    .num_in    (num_in),
    .len_in    (len_in),
    .out_ready (out_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .busy      (busy),
    .code_len  (code_len),
    .err       (err),
    .md_end    (md_end)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Encode one word; returns in the md_end cycle.
  task automatic run_word(
    input logic [63:0] num,
    input logic [7:0]  len,
    input bit          toggle,
    input int          exp_len,
    input int          ign_cycle
  );
    logic [127:0] got;
    logic [127:0] exp;
    int           nbits;
    int           last_at;
    bit           done;
    bit           prev_stall;
    logic         prev_bit;
    logic         prev_last;
    got        = '0;
    exp        = '0;
    nbits      = 0;
    last_at    = -1;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    prev_last  = 1'b0;
    for (int i = 0; i < int'(len) - 1; i++) exp[i] = 1'b0;
    for (int j = 0; j < int'(len); j++)
      exp[int'(len) - 1 + j] = num[int'(len) - 1 - j];
    md_start  = 1'b1;
    num_in    = num;
    len_in    = len;
    out_ready = 1'b1;
    step();
    md_start = 1'b0;
    check("md_end_pulse", md_end, 1'b0);
    check("code_len", code_len, 128'(exp_len));
    check("busy", busy, 1'b1);
    check("first_valid", bit_valid, 1'b1);
    for (int c = 0; c < 400 && !done; c++) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (c == ign_cycle) begin
        md_start = 1'b1;
        num_in   = 64'hFFFF;
        len_in   = 8'd16;
      end else begin
        md_start = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", bit_valid, 1'b1);
        check("stall_bit", bit_out, prev_bit);
        check("stall_last", bit_last, prev_last);
      end
      if (bit_valid && out_ready) begin
        got[nbits] = bit_out;
        if (bit_last) begin
          last_at = nbits;
          done    = 1'b1;
        end
        nbits++;
      end
      prev_stall = bit_valid && !out_ready;
      prev_bit   = bit_out;
      prev_last  = bit_last;
      step();
    end
    md_start  = 1'b0;
    out_ready = 1'b1;
    check("nbits", 128'(nbits), 128'(exp_len));
    check("last_pos", 128'(last_at), 128'(exp_len - 1));
    check("code_bits", got, exp);
    check("valid_drop", bit_valid, 1'b0);
    check("busy_done", busy, 1'b1);
    check("md_end_early", md_end, 1'b0);
    step();
    check("md_end", md_end, 1'b1);
    check("err_ok", err, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    rstn      = 1'b0;
    md_start  = 1'b0;
    num_in    = '0;
    len_in    = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", bit_valid, 1'b0);
    check("rst_bit", bit_out, 1'b0);
    check("rst_last", bit_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_code_len", code_len, 8'd0);
    check("rst_err", err, 1'b0);
    check("rst_md_end", md_end, 1'b0);
    rstn = 1'b1;
    step();

    // 5 -> 0,0,1,0,1
    run_word(64'd5, 8'd3, 1'b0, 5, -1);
    // 1 -> 1, started back-to-back in the md_end cycle
    run_word(64'd1, 8'd1, 1'b0, 1, -1);
    step();
    check("md_end_one", md_end, 1'b0);

    // len 0 rejected
    md_start = 1'b1;
    num_in   = 64'd7;
    len_in   = 8'd0;
    step();
    md_start = 1'b0;
    check("e0_valid", bit_valid, 1'b0);
    check("e0_code_len", code_len, 8'd0);
    check("e0_md_end_early", md_end, 1'b0);
    step();
    check("e0_valid2", bit_valid, 1'b0);
    check("e0_md_end", md_end, 1'b1);
    check("e0_err", err, 1'b1);
    step();
    check("e0_md_end_off", md_end, 1'b0);
    check("e0_err_off", err, 1'b0);

    // len 65 rejected
    md_start = 1'b1;
    len_in   = 8'd65;
    step();
    md_start = 1'b0;
    step();
    check("e65_md_end", md_end, 1'b1);
    check("e65_err", err, 1'b1);
    step();

    // Max length with stalls
    run_word(64'h8000_0000_0000_0000, 8'd64, 1'b1, 127, -1);
    step();

    // 6 -> 0,0,1,1,0 with a stray md_start in BODY
    run_word(64'd6, 8'd3, 1'b0, 5, 3);
    // Request right after is still accepted
    run_word(64'd2, 8'd2, 1'b1, 3, -1);
    step();

    // Reset in the middle of the prefix
    md_start = 1'b1;
    num_in   = 64'h3FF;
    len_in   = 8'd10;
    out_ready = 1'b1;
    step();
    md_start = 1'b0;
    step();
    step();
    check("mid_valid", bit_valid, 1'b1);
    check("mid_bit", bit_out, 1'b0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("abort_valid", bit_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_code_len", code_len, 8'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("abort_no_md_end", md_end, 1'b0);
      check("abort_idle", bit_valid, 1'b0);
    end
    // 0x2D, len 6 -> 00000101101
    run_word(64'h2D, 8'd6, 1'b0, 11, -1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
